piano_key_ctrl: RTL and testbench
=================================

// Module: piano_key_ctrl
// PURPOSE
//  Front end of the piano datapath, directly upstream of the buzzer tone counter.
//  Synchronises and debounces 8 raw piano keys and picks one note (lowest index wins).
//  Drives the tone counter's enable (counter_en) plus the half-period divisor for that note.
//  Enforces a minimum note length so short taps are still audible.
// PARAMETERS
//  DEBOUNCE_CYCLES  20       consecutive stable cycles before a key state is accepted (>=1)
//  MIN_NOTE_CYCLES  2500000  minimum cycles counter_en stays high per note (>=1)
//  DIV_W            17       width of half_period output
// PORTS
//  clk          in   1      system clock, 50 MHz, rising edge
//  rst          in   1      asynchronous, active-high reset
//  keys_raw     in   8      raw key levels, 1 = pressed, asynchronous to clk
//  mute         in   1      synchronous; 1 forces silence (IDLE) while high
//  counter_en   out  1      enable to tone counter; high only in PLAY
//  half_period  out  DIV_W  tone counter half-period in clk cycles for note_idx
//  note_idx     out  3      index of note being played (0=C4 .. 7=C5)
//  key_stable   out  8      debounced key vector
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sync/debounce/hold counters 0.
//  Sync: keys_raw passes through 2 flops per bit (s1 -> s2).
//  Debounce, per key: while s2 != key_stable, cnt++; else cnt = 0.
//   - key_stable flips when cnt reaches DEBOUNCE_CYCLES-1 with mismatch still present; cnt -> 0.
//   - Any single-cycle agreement resets cnt (glitch rejected).
//  Encode: sel = lowest set bit of key_stable; any = |key_stable.
//  Note ROM (half periods @50 MHz):
//   - 0:95556, 1:85131, 2:75843, 3:71586, 4:63776, 5:56818, 6:50619, 7:47778.
//  FSM (registered, one transition per clock):
//   - IDLE: counter_en=0. any && !mute -> LOAD.
//   - LOAD: counter_en=0 for exactly 1 cycle; latch note_idx<=sel, half_period<=ROM[sel]; hold<=0 -> PLAY.
//   - PLAY: counter_en=1; hold++ saturating at MIN_NOTE_CYCLES. Checked in this order:
//     1. mute -> IDLE.
//     2. any && sel!=note_idx -> LOAD (immediate, ignores hold; 1-cycle gap restarts tone counter).
//     3. !any && hold>=MIN_NOTE_CYCLES-1 -> IDLE.
//     4. !any && hold short -> stay PLAY (tap extension).
//     5. same key held -> stay PLAY.
//  note_idx/half_period hold last value in IDLE; change only in LOAD.
//  Latency: keys_raw edge sampled at clk edge E0 -> key_stable at E0+DEBOUNCE_CYCLES+1.
//   - LOAD at +2; counter_en high at E0+DEBOUNCE_CYCLES+3.
//  Simultaneous press of several keys: lowest index plays.
//   - Releasing it switches to the next lowest via LOAD.
//  Re-press of same key during tap extension: stays PLAY, no gap.
//  rst mid-note: counter_en drops asynchronously to 0, debounce state lost.
//   - Held keys are re-debounced after release of rst.
//  hold counter width = $clog2(MIN_NOTE_CYCLES+1); no wrap (saturates).
// TESTING (bench with DEBOUNCE_CYCLES=4, MIN_NOTE_CYCLES=10)
//  1. rst=1 then 0, keys_raw=0 -> all outputs 0 for 50 cycles.
//  2. keys_raw=8'h10 held from edge E0 -> key_stable=8'h10 at E0+5; LOAD at E0+6.
//     counter_en=1 from E0+7; note_idx=4; half_period=63776.
//  3. keys_raw bit0 glitch 3 cycles high -> key_stable stays 0; counter_en never asserts.
//  4. Tap: bit2 pressed until key_stable high, then released -> counter_en high exactly 10 cycles; returns to IDLE.
//  5. Hold 8'h08, then add 8'h01 -> after debounce, one cycle counter_en=0.
//     Then note_idx=0, half_period=95556; release bit0 -> gap, note_idx=3.
//  6. PLAY, then mute=1 -> counter_en=0 next cycle; rst pulse mid-note -> counter_en=0 immediately, asynchronous.

Source files
------------

// File: rtl/piano_key_ctrl_if.sv
// Key input / tone-counter control bundle between the piano key front end and its neighbours.
// The master drives the raw keys and mute; the slave (piano_key_ctrl) drives the tone controls.
interface piano_key_ctrl_if #(
  parameter int DIV_W = 17
);
  logic [7:0]       keys_raw;
  logic             mute;
  logic             counter_en;
  logic [DIV_W-1:0] half_period;
  logic [2:0]       note_idx;
  logic [7:0]       key_stable;

  modport master (
    output keys_raw, mute,
    input  counter_en, half_period, note_idx, key_stable
  );

  modport slave (
    input  keys_raw, mute,
    output counter_en, half_period, note_idx, key_stable
  );
endinterface

// File: rtl/piano_key_ctrl.sv
// Piano key front end: synchronise and debounce 8 keys, pick the lowest pressed note,
// and drive the tone counter enable and half-period with a minimum audible note length.
module piano_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int MIN_NOTE_CYCLES = 2500000,
  parameter int DIV_W           = 17
) (
  input logic            clk,
  input logic            rst,
  piano_key_ctrl_if.slave bus
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(MIN_NOTE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_NOTE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(MIN_NOTE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Half periods in 50 MHz clock cycles, C4 .. C5.
  function automatic logic [DIV_W-1:0] note_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return DIV_W'(95556);
      3'd1:    return DIV_W'(85131);
      3'd2:    return DIV_W'(75843);
      3'd3:    return DIV_W'(71586);
      3'd4:    return DIV_W'(63776);
      3'd5:    return DIV_W'(56818);
      3'd6:    return DIV_W'(50619);
      default: return DIV_W'(47778);
    endcase
  endfunction

  logic [7:0]       key_sync_p0;
  logic [7:0]       key_sync_p1;
  logic [7:0]       key_stable_r;
  logic [CNT_W-1:0] db_cnt [8];

  state_t            state;
  logic              counter_en_r;
  logic [2:0]        note_idx_r;
  logic [DIV_W-1:0]  half_period_r;
  logic [HOLD_W-1:0] hold;

  logic [2:0] sel;
  logic       any;

  // Stage p0/p1: two-flop synchroniser, then per-key debounce against the accepted state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sync_p0  <= '0;
      key_sync_p1  <= '0;
      key_stable_r <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      key_sync_p0 <= bus.keys_raw;
      key_sync_p1 <= key_sync_p0;
      for (int i = 0; i < 8; i++) begin
        if (key_sync_p1[i] != key_stable_r[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            key_stable_r[i] <= key_sync_p1[i];
            db_cnt[i]       <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    sel = lowest_set(key_stable_r);
    any = |key_stable_r;
  end

  // Note FSM: a new note always passes through LOAD so the tone counter sees a one-cycle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      counter_en_r  <= 1'b0;
      note_idx_r    <= '0;
      half_period_r <= '0;
      hold          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any && !bus.mute) state <= LOAD;
        end
        LOAD: begin
          note_idx_r    <= sel;
          half_period_r <= note_rom(sel);
          hold          <= '0;
          state         <= PLAY;
          counter_en_r  <= 1'b1;
        end
        PLAY: begin
          if (hold != HOLD_MAX) hold <= hold + 1'b1;
          if (bus.mute) begin
            state        <= IDLE;
            counter_en_r <= 1'b0;
          end else if (any && sel != note_idx_r) begin
            state        <= LOAD;
            counter_en_r <= 1'b0;
          end else if (!any && hold >= HOLD_END) begin
            state        <= IDLE;
            counter_en_r <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          counter_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.counter_en  = counter_en_r;
  assign bus.half_period = half_period_r;
  assign bus.note_idx    = note_idx_r;
  assign bus.key_stable  = key_stable_r;

endmodule

// File: tb/tb_piano_key_ctrl.sv
// Bench for piano_key_ctrl with DEBOUNCE_CYCLES=4, MIN_NOTE_CYCLES=10; expected note starts
// are queued as keys are driven and checked whenever counter_en rises.
module tb_piano_key_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  piano_key_ctrl_if #(.DIV_W(17)) bus ();

  piano_key_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MIN_NOTE_CYCLES(10),
    .DIV_W(17)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int rom [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected note index per counter_en rising edge.
  int   exp_q [$];
  int   e;
  int   run_len  = 0;
  int   last_len = 0;
  int   gap_len  = 0;
  int   last_gap = 0;
  logic prev_en  = 1'b0;

  always @(negedge clk) begin
    if (bus.counter_en && !prev_en) begin
      last_gap = gap_len;
      if (exp_q.size() == 0) begin
        chk("unexpected_note", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("note_idx", 32'(bus.note_idx), e);
        chk("half_period", 32'(bus.half_period), rom[e]);
      end
      run_len = 0;
    end
    if (bus.counter_en) run_len++;
    else if (prev_en) begin
      last_len = run_len;
      gap_len  = 0;
    end
    if (!bus.counter_en) gap_len++;
    prev_en = bus.counter_en;
  end

  logic [7:0] seen;
  bit         got_it;

  initial begin
    bus.keys_raw = '0;
    bus.mute     = 1'b0;

    // Reset and quiet idle.
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("reset_idle", {3'b0, bus.counter_en, bus.half_period, bus.note_idx, bus.key_stable}, 0);
    end

    // Single key press: exact latency.
    bus.keys_raw = 8'h10;
    exp_q.push_back(4);
    tick(5);
    chk("stable_e4", 32'(bus.key_stable), 0);
    tick(1);
    chk("stable_e5", 32'(bus.key_stable), 32'h10);
    tick(1);
    chk("en_e6", 32'(bus.counter_en), 0);
    tick(1);
    chk("en_e7", 32'(bus.counter_en), 1);
    chk("note_e7", 32'(bus.note_idx), 4);
    chk("half_e7", 32'(bus.half_period), 63776);
    tick(20);
    bus.keys_raw = 8'h00;
    tick(30);
    chk("release_idle", 32'(bus.counter_en), 0);
    chk("note_kept", 32'(bus.note_idx), 4);

    // Glitch of 3 cycles is rejected.
    bus.keys_raw = 8'h01;
    tick(3);
    bus.keys_raw = 8'h00;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen |= bus.key_stable;
    end
    chk("glitch_stable", 32'(seen), 0);
    chk("glitch_en", 32'(bus.counter_en), 0);

    // Short tap is stretched to the minimum note length.
    bus.keys_raw = 8'h04;
    exp_q.push_back(2);
    got_it = 1'b0;
    for (int i = 0; i < 40 && !got_it; i++) begin
      tick(1);
      got_it = bus.key_stable[2];
    end
    if (!got_it) chk("tap_timeout", 0, 1);
    bus.keys_raw = 8'h00;
    tick(30);
    chk("tap_len", 32'(last_len), 10);
    chk("tap_idle", 32'(bus.counter_en), 0);

    // Lower key overrides, then release falls back, each with a one-cycle gap.
    bus.keys_raw = 8'h08;
    exp_q.push_back(3);
    tick(20);
    bus.keys_raw = 8'h09;
    exp_q.push_back(0);
    tick(20);
    chk("switch_gap", 32'(last_gap), 1);
    chk("switch_note", 32'(bus.note_idx), 0);
    chk("switch_half", 32'(bus.half_period), 95556);
    bus.keys_raw = 8'h08;
    exp_q.push_back(3);
    tick(20);
    chk("back_gap", 32'(last_gap), 1);
    chk("back_note", 32'(bus.note_idx), 3);
    bus.keys_raw = 8'h00;
    tick(30);
    chk("multi_idle", 32'(bus.counter_en), 0);

    // Mute silences next cycle; resumes when released.
    bus.keys_raw = 8'h80;
    exp_q.push_back(7);
    tick(15);
    chk("pre_mute_en", 32'(bus.counter_en), 1);
    bus.mute = 1'b1;
    tick(1);
    chk("mute_en", 32'(bus.counter_en), 0);
    tick(3);
    chk("mute_hold", 32'(bus.counter_en), 0);
    bus.mute = 1'b0;
    exp_q.push_back(7);
    tick(5);
    chk("unmute_en", 32'(bus.counter_en), 1);

    // Asynchronous reset mid-note, then the held key is re-debounced.
    #3 rst = 1'b1;
    #1;
    chk("rst_async_en", 32'(bus.counter_en), 0);
    chk("rst_async_stable", 32'(bus.key_stable), 0);
    chk("rst_async_note", 32'(bus.note_idx), 0);
    tick(2);
    rst = 1'b0;
    exp_q.push_back(7);
    tick(4);
    chk("rst_redebounce", 32'(bus.key_stable), 0);
    tick(20);
    chk("rst_replay", 32'(bus.counter_en), 1);
    bus.keys_raw = 8'h00;
    tick(40);
    chk("final_idle", 32'(bus.counter_en), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
